image_stream_encoder: RTL and testbench

Serializes a full binary image (ROWS rows of WIDTH bits) into a stream of one-row slices with a row index, for returning BNN images and feature maps from the fabric to the capture interface. It is the transmit counterpart of the slice-based image stream decoder: each beat carries one row on `slice_o` and its row number on `sel_o`, qualified by `valid_o`. A valid/ready handshake lets the downstream consumer stall the stream at any beat.

---
 rtl/image_stream_encoder.sv | 139 +++++++++++++
 tb/tb_image_stream_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_encoder.sv
// image_stream_encoder
//
// Purpose: takes a complete binary image of ROWS rows, each WIDTH bits wide,
// and sends it out one row per beat. Each beat carries the row data and its
// row number. A valid/ready handshake lets the downstream consumer stall the
// stream. This block returns BNN images and feature maps from the fabric to
// the capture interface, and is the transmit side of the slice-based image
// stream decoder.
//
// Ports:
//   clk      - single rising-edge clock
//   rst      - asynchronous active-high reset
//   load_i   - image-present strobe, only looked at while ready_o is high
//   image_i  - image to send; row r is image_i[r]
//   ready_o  - encoder is idle and will accept load_i
//   slice_o  - data of the current row
//   sel_o    - row index of the current row
//   valid_o  - slice_o/sel_o carry a beat
//   ready_i  - downstream accepts the current beat
//   done_o   - one-cycle pulse after the last row has been accepted

module image_stream_encoder #(
    parameter int ROWS  = 8,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic [ROWS-1:0][WIDTH-1:0]  image_i,
    output logic                        ready_o,
    output logic [WIDTH-1:0]            slice_o,
    output logic [$clog2(ROWS)-1:0]     sel_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        done_o
);

    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                       state_q, state_d;
    logic [ROWS-1:0][WIDTH-1:0]   img_q, img_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [ROW_W-1:0]             rowNext;
    logic [WIDTH-1:0]             slice_q, slice_d;
    logic [ROW_W-1:0]             sel_q, sel_d;
    logic                         valid_q, valid_d;
    logic                         done_q, done_d;
    logic                         beatAccepted;

    // The encoder can only take a new image while it is idle. This output is
    // decoded straight from the state, with no extra register stage.
    assign ready_o = (state_q == IDLE);

    assign slice_o = slice_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;

    // A beat moves on any edge where we offer data and the consumer accepts it.
    assign beatAccepted = valid_q && ready_i;
    assign rowNext      = row_q + 1'b1;

    // Next-state logic. Every register holds by default. This is what freezes
    // slice/sel during a stall. The exception is done, which defaults to 0,
    // so it can only ever be a single-cycle pulse. The image is copied into
    // img_q at load time, so later changes on image_i cannot disturb the
    // image that is in flight. The last row is checked before row_q is
    // incremented, so row_q never wraps.
    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        row_d   = row_q;
        slice_d = slice_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                slice_d = '0;
                sel_d   = '0;
                if (load_i) begin
                    img_d   = image_i;
                    row_d   = '0;
                    slice_d = image_i[0];
                    sel_d   = '0;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beatAccepted) begin
                    if (row_q == LAST_ROW) begin
                        valid_d = 1'b0;
                        slice_d = '0;
                        sel_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d   = rowNext;
                        slice_d = img_q[rowNext];
                        sel_d   = rowNext;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset is asynchronous, so a reset in the
    // middle of a transfer abandons it at once, even between clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            img_q   <= '0;
            row_q   <= '0;
            slice_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            row_q   <= row_d;
            slice_q <= slice_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_image_stream_encoder.sv
// tb_image_stream_encoder
//
// Purpose: directed bench for image_stream_encoder with ROWS=8, WIDTH=8.
// Expected values are hand-computed from the row pattern, or come from a
// reassembly of the image that the bench builds itself.
//
// Ports: none (top-level bench).

module tb_image_stream_encoder;

    localparam int ROWS  = 8;
    localparam int WIDTH = 8;

    logic                        clk;
    logic                        rst;
    logic                        load_i;
    logic [ROWS-1:0][WIDTH-1:0]  image_i;
    logic                        ready_o;
    logic [WIDTH-1:0]            slice_o;
    logic [2:0]                  sel_o;
    logic                        valid_o;
    logic                        ready_i;
    logic                        done_o;

    int checks = 0;
    int errors = 0;

    image_stream_encoder #(.ROWS(ROWS), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_i),
        .image_i (image_i),
        .ready_o (ready_o),
        .slice_o (slice_o),
        .sel_o   (sel_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .done_o  (done_o)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then sample 1 unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs that the next edge will see.
    task automatic applyStimulus(input logic load, input logic [ROWS-1:0][WIDTH-1:0] img,
                                 input logic rdy);
        load_i  = load;
        image_i = img;
        ready_i = rdy;
    endtask

    // One comparison. The failure count is stepped here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all five DUT outputs at once.
    task automatic checkAll(input string tag, input logic r, input logic v,
                            input logic [2:0] s, input logic [7:0] d, input logic dn);
        checkOutput({tag, ".ready"}, 32'(ready_o), 32'(r));
        checkOutput({tag, ".valid"}, 32'(valid_o), 32'(v));
        checkOutput({tag, ".sel"},   32'(sel_o),   32'(s));
        checkOutput({tag, ".slice"}, 32'(slice_o), 32'(d));
        checkOutput({tag, ".done"},  32'(done_o),  32'(dn));
    endtask

    logic [ROWS-1:0][WIDTH-1:0] walkImg;
    logic [ROWS-1:0][WIDTH-1:0] altImg;
    logic [ROWS-1:0][WIDTH-1:0] rndImg;
    logic [ROWS-1:0][WIDTH-1:0] capImg;

    // Directed sequence: reset, basic stream, stalls, ignored loads,
    // reset mid-stream, then random images reassembled by the bench.
    initial begin
        int expRow;
        int k;
        int beats;
        int guard;
        bit seenDone;

        for (int r = 0; r < ROWS; r++) begin
            walkImg[r] = 8'(1 << r);
            altImg[r]  = 8'(8'hA0 + r);
        end

        // ---- Reset values, checked between clock edges ----
        rst = 1'b1;
        applyStimulus(1'b1, walkImg, 1'b1);
        #2;
        checkAll("reset_async", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        checkAll("reset_load_ignored", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, walkImg, 1'b1);
        rst = 1'b0;
        tick();
        checkAll("idle_after_reset", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        // ---- Basic stream with ready_i held high ----
        applyStimulus(1'b1, walkImg, 1'b1);
        tick();
        load_i = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            checkAll($sformatf("basic_row%0d", r), 1'b0, 1'b1, 3'(r), 8'(1 << r), 1'b0);
            tick();
        end
        checkAll("basic_done", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        tick();
        checkAll("basic_done_clear", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        // ---- Stalls (first and last beat included) and a frozen image ----
        applyStimulus(1'b1, walkImg, 1'b0);
        tick();
        load_i = 1'b0;
        expRow = 0;
        k = 0;
        while (expRow < ROWS && k < 100) begin
            checkAll($sformatf("stall_k%0d", k), 1'b0, 1'b1, 3'(expRow), 8'(1 << expRow), 1'b0);
            ready_i = ((k % 3) == 1);
            image_i = {$urandom, $urandom};
            tick();
            if (ready_i) expRow++;
            k++;
        end
        checkOutput("stall_rows_delivered", 32'(expRow), 32'(ROWS));
        checkAll("stall_done", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);

        // ---- Loads during SEND and on the last beat are ignored ----
        tick();
        applyStimulus(1'b1, walkImg, 1'b1);
        tick();
        load_i = 1'b0;
        image_i = altImg;
        for (int r = 0; r < ROWS; r++) begin
            checkAll($sformatf("ign_row%0d", r), 1'b0, 1'b1, 3'(r), 8'(1 << r), 1'b0);
            load_i = (r == 3 || r == 7);
            tick();
        end
        checkAll("ign_done", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        // A load in the done cycle is accepted.
        applyStimulus(1'b1, altImg, 1'b1);
        tick();
        load_i = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            checkAll($sformatf("done_load_row%0d", r), 1'b0, 1'b1, 3'(r), 8'(8'hA0 + r), 1'b0);
            tick();
        end
        checkAll("done_load_done", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        tick();

        // ---- Reset while sel_o=3 is held under stall ----
        applyStimulus(1'b1, walkImg, 1'b1);
        tick();
        load_i = 1'b0;
        tick();
        tick();
        tick();
        ready_i = 1'b0;
        tick();
        checkAll("mid_stall_row3", 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkAll("mid_reset_async", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        ready_i = 1'b1;
        tick();
        checkAll("mid_after_release", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, altImg, 1'b1);
        tick();
        load_i = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            checkAll($sformatf("restart_row%0d", r), 1'b0, 1'b1, 3'(r), 8'(8'hA0 + r), 1'b0);
            tick();
        end
        checkAll("restart_done", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        tick();

        // ---- Random images with random ready_i, reassembled by the bench ----
        for (int n = 0; n < 1000; n++) begin
            rndImg = {$urandom, $urandom};
            capImg = '0;
            beats = 0;
            seenDone = 1'b0;
            guard = 0;
            applyStimulus(1'b1, rndImg, 1'(($urandom_range(0, 1))));
            tick();
            load_i = 1'b0;
            while (!seenDone && guard < 200) begin
                ready_i = 1'($urandom_range(0, 1));
                if (valid_o && ready_i) begin
                    if (sel_o != 3'(beats)) begin
                        checkOutput($sformatf("loop%0d_order", n), 32'(sel_o), 32'(beats));
                    end
                    capImg[sel_o] = slice_o;
                    beats++;
                end
                tick();
                seenDone = done_o;
                guard++;
            end
            if (!seenDone) begin
                checkOutput($sformatf("loop%0d_timeout", n), 32'(seenDone), 32'd1);
            end
            checkOutput($sformatf("loop%0d_image", n), capImg, rndImg);
            checkOutput($sformatf("loop%0d_beats", n), 32'(beats), 32'(ROWS));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
